// File: rtl/maze_move_sequencer.sv
// Single-move sequencer: range-checks a direction pulse, reads the wall bit through a
// req/gnt map port, then commits the position, counts moves and flags the goal cell.
module maze_move_sequencer #(
  parameter int unsigned GRID_W  = 16,
  parameter int unsigned GRID_H  = 12,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned START_X = 1,
  parameter int unsigned START_Y = 1,
  parameter int unsigned GOAL_X  = 14,
  parameter int unsigned GOAL_Y  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         move_req,
  input  logic               restart,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rdata,
  output logic [COORD_W-1:0] player_x,
  output logic [COORD_W-1:0] player_y,
  output logic [15:0]        moves,
  output logic               busy,
  output logic               bump,
  output logic               won
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WON} state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]  tx_q, tx_d, ty_q, ty_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         moves_q, moves_d;
  logic                bump_q, bump_d;

  logic [COORD_W-1:0]  nx, ny;
  logic                dir_valid, off_grid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= COORD_W'(START_X);
      y_q     <= COORD_W'(START_Y);
      tx_q    <= '0;
      ty_q    <= '0;
      addr_q  <= '0;
      moves_q <= '0;
      bump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      addr_q  <= addr_d;
      moves_q <= moves_d;
      bump_q  <= bump_d;
    end
  end

  // Only the four one-hot codes decode; zero or multiple bits fall to default and are ignored.
  always_comb begin
    nx        = x_q;
    ny        = y_q;
    dir_valid = 1'b0;
    off_grid  = 1'b0;
    case (move_req)
      4'b1000: begin dir_valid = 1'b1; off_grid = (y_q == '0);                     ny = y_q - COORD_W'(1); end
      4'b0100: begin dir_valid = 1'b1; off_grid = (y_q == COORD_W'(GRID_H - 1)); ny = y_q + COORD_W'(1); end
      4'b0010: begin dir_valid = 1'b1; off_grid = (x_q == '0);                     nx = x_q - COORD_W'(1); end
      4'b0001: begin dir_valid = 1'b1; off_grid = (x_q == COORD_W'(GRID_W - 1)); nx = x_q + COORD_W'(1); end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    addr_d  = addr_q;
    moves_d = moves_q;
    bump_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dir_valid) begin
          if (off_grid) begin
            bump_d = 1'b1;
          end else begin
            tx_d    = nx;
            ty_d    = ny;
            addr_d  = ADDR_W'(ny) * ADDR_W'(GRID_W) + ADDR_W'(nx);
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rdata) begin
          bump_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          x_d = tx_q;
          y_d = ty_q;
          if (moves_q != '1) moves_d = moves_q + 16'd1;
          state_d = (tx_q == COORD_W'(GOAL_X) && ty_q == COORD_W'(GOAL_Y)) ? S_WON : S_IDLE;
        end
      end
      S_WON: ;
      default: state_d = S_IDLE;
    endcase
    // Restart wins over everything, including a read already in flight.
    if (restart) begin
      state_d = S_IDLE;
      x_d     = COORD_W'(START_X);
      y_d     = COORD_W'(START_Y);
      moves_d = '0;
      bump_d  = 1'b0;
    end
  end

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = addr_q;
  assign busy     = (state_q == S_REQ) || (state_q == S_WAIT);
  assign won      = (state_q == S_WON);
  assign bump     = bump_q;
  assign player_x = x_q;
  assign player_y = y_q;
  assign moves    = moves_q;

endmodule

// File: tb/tb_maze_move_sequencer.sv
// Scoreboard bench for maze_move_sequencer: a reference walk model predicts each move's
// outcome and map address; a negedge monitor matches DUT outputs against those queues.
module tb_maze_move_sequencer;
  localparam int unsigned GW = 16;
  localparam int unsigned GH = 12;
  localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, LEFT = 4'b0010, RIGHT = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  move_req;
  logic        restart;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_gnt;
  logic        mem_rdata;
  logic [7:0]  player_x, player_y;
  logic [15:0] moves;
  logic        busy, bump, won;

  maze_move_sequencer #(
    .GRID_W(16), .GRID_H(12), .COORD_W(8), .ADDR_W(8),
    .START_X(1), .START_Y(1), .GOAL_X(14), .GOAL_Y(10)
  ) dut (
    .clk(clk), .reset(reset), .move_req(move_req), .restart(restart),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .player_x(player_x), .player_y(player_y), .moves(moves),
    .busy(busy), .bump(bump), .won(won)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bump;
    logic [7:0]  x, y;
    logic [15:0] moves;
    logic        won;
    int unsigned t0, lat;
  } res_t;

  res_t        sq[$];
  logic [7:0]  aq[$];
  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0;
  bit          quiet = 1'b1;
  logic        wall [0:255];
  int          mx = 1, my = 1;
  logic [15:0] mm = '0;
  bit          mwon = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Map memory: data is valid only the cycle after acceptance; otherwise it shows the inverse.
  logic       rd_vld = 1'b0;
  logic [7:0] rd_addr = '0;
  always @(posedge clk) begin
    rd_vld  <= mem_req & mem_gnt;
    rd_addr <= mem_addr;
  end
  assign mem_rdata = rd_vld ? wall[rd_addr] : ~wall[rd_addr];

  logic [7:0]  px = 8'd1, py = 8'd1;
  logic [15:0] pm = '0;
  res_t        mon_e;
  always @(negedge clk) begin
    if (reset && !quiet) begin
      if (mem_req) begin
        if (aq.size() == 0) check("spurious_req", mem_req, 1'b0);
        else begin
          check("mem_addr", mem_addr, aq[0]);
          check("busy_req", busy, 1'b1);
          if (mem_gnt) void'(aq.pop_front());
        end
      end
      if (bump || player_x != px || player_y != py || moves != pm) begin
        if (sq.size() == 0) begin
          check("unexpected_bump", bump, 1'b0);
          check("unexpected_pos", {player_x, player_y}, {px, py});
          check("unexpected_moves", moves, pm);
        end else begin
          mon_e = sq.pop_front();
          check("bump", bump, mon_e.bump);
          check("player_x", player_x, mon_e.x);
          check("player_y", player_y, mon_e.y);
          check("moves", moves, mon_e.moves);
          check("won", won, mon_e.won);
          check("latency", cyc - mon_e.t0, mon_e.lat);
        end
      end
    end
    px = player_x;
    py = player_y;
    pm = moves;
  end

  // Drives one pulse; if the idle DUT should act on it, queues the predicted outcome.
  task automatic pulse(input logic [3:0] dir, input int unsigned stall, input bit abandon);
    int   tx, ty;
    bit   off;
    res_t e;
    @(posedge clk); #1;
    move_req = dir;
    if ($countones(dir) == 1) begin
      tx = mx; ty = my; off = 1'b0;
      case (dir)
        UP:      begin off = (my == 0);      ty = my - 1; end
        DOWN:    begin off = (my == GH - 1); ty = my + 1; end
        LEFT:    begin off = (mx == 0);      tx = mx - 1; end
        default: begin off = (mx == GW - 1); tx = mx + 1; end
      endcase
      e.t0 = cyc;
      if (off) begin
        e.bump = 1'b1; e.lat = 1;
        e.x = 8'(mx); e.y = 8'(my); e.moves = mm; e.won = mwon;
        sq.push_back(e);
      end else begin
        aq.push_back(8'(ty * GW + tx));
        if (!abandon) begin
          e.lat = 3 + stall;
          if (wall[ty * GW + tx]) e.bump = 1'b1;
          else begin
            e.bump = 1'b0;
            mx = tx; my = ty;
            if (mm != 16'hFFFF) mm = mm + 16'd1;
            mwon = (tx == 14 && ty == 10);
          end
          e.x = 8'(mx); e.y = 8'(my); e.moves = mm; e.won = mwon;
          sq.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    move_req = '0;
  endtask

  task automatic raw_pulse(input logic [3:0] dir);
    @(posedge clk); #1;
    move_req = dir;
    @(posedge clk); #1;
    move_req = '0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && (sq.size() != 0 || aq.size() != 0); i++) @(negedge clk);
    if (sq.size() != 0 || aq.size() != 0) begin
      check("timeout_pending", sq.size() + aq.size(), 0);
      sq.delete();
      aq.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic walk(input logic [3:0] dir, input int n);
    for (int i = 0; i < n; i++) begin
      pulse(dir, 0, 1'b0);
      wait_done();
    end
  endtask

  task automatic model_home();
    mx = 1; my = 1; mm = '0; mwon = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) wall[i] = 1'b0;
    wall[1] = 1'b1;
    reset = 1'b0; move_req = '0; restart = 1'b0; mem_gnt = 1'b1;
    #12;
    check("rst_x", player_x, 8'd1);
    check("rst_y", player_y, 8'd1);
    check("rst_moves", moves, 16'd0);
    check("rst_sigs", {mem_req, busy, bump, won}, 4'b0000);
    check("rst_addr", mem_addr, 8'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1 quiet = 1'b0;

    pulse(UP, 0, 1'b0);                 // (1,0) is a wall
    wait_done();
    pulse(4'b0000, 0, 1'b0);
    pulse(4'b0011, 0, 1'b0);
    pulse(4'b1100, 0, 1'b0);
    wait_done();
    walk(RIGHT, 1);                     // (2,1), addr 18
    walk(LEFT, 2);
    walk(DOWN, 4);                      // (0,5)
    pulse(LEFT, 0, 1'b0);               // off-grid bump at N+1
    wait_done();

    mem_gnt = 1'b0;
    pulse(RIGHT, 5, 1'b0);
    @(posedge clk); #1;
    move_req = DOWN;
    check("busy_stall", busy, 1'b1);
    @(posedge clk); #1;
    move_req = '0;
    repeat (3) @(posedge clk);
    #1 mem_gnt = 1'b1;
    wait_done();                        // now (1,5)

    walk(RIGHT, 13);
    walk(DOWN, 4);                      // (14,9)
    @(posedge clk); #1;
    quiet = 1'b1;
    force dut.moves_d = 16'hFFFE;
    @(posedge clk); #1;
    release dut.moves_d;
    mm = 16'hFFFE;
    @(negedge clk); #1 quiet = 1'b0;
    walk(LEFT, 1);                      // 16'hFFFF
    walk(DOWN, 1);                      // saturated
    walk(RIGHT, 1);                     // (14,10) goal
    raw_pulse(LEFT);
    wait_done();
    check("won_hold", won, 1'b1);
    check("won_pos", {player_x, player_y}, {8'd14, 8'd10});

    @(posedge clk); #1;
    quiet = 1'b1;
    restart = 1'b1; move_req = LEFT;
    @(posedge clk); #1;
    restart = 1'b0; move_req = '0;
    check("restart_pos", {player_x, player_y}, {8'd1, 8'd1});
    check("restart_moves", moves, 16'd0);
    check("restart_sigs", {won, mem_req, busy, bump}, 4'b0000);
    model_home();
    @(negedge clk); #1 quiet = 1'b0;
    wait_done();

    pulse(RIGHT, 0, 1'b1);              // restart while in WAIT drops the read
    @(posedge clk); #1;
    check("abandon_wait", {busy, mem_req}, 2'b10);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    wait_done();
    check("abandon_pos", {player_x, player_y}, {8'd1, 8'd1});
    check("abandon_moves", moves, 16'd0);

    walk(RIGHT, 1);                     // (2,1), moves 1
    pulse(RIGHT, 0, 1'b1);
    @(posedge clk); #1;
    check("pre_reset_wait", {busy, mem_req}, 2'b10);
    quiet = 1'b1;
    reset = 1'b0;
    #1;
    check("async_rst_pos", {player_x, player_y}, {8'd1, 8'd1});
    check("async_rst_moves", moves, 16'd0);
    check("async_rst_sigs", {mem_req, busy, bump, won}, 4'b0000);
    check("async_rst_addr", mem_addr, 8'd0);
    sq.delete();
    aq.delete();
    model_home();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1 quiet = 1'b0;
    walk(DOWN, 1);                      // (1,2) after reset
    check("post_reset_pos", {player_x, player_y}, {8'd1, 8'd2});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
